// File: rtl/m_mem_seq_if.sv
// Data-bus handshake between the M-stage memory sequencer (master) and data memory (slave).
// Requests are held until bus_ack; bus_rdata is valid in the ack cycle.
interface m_mem_seq_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/m_mem_seq.sv
// M-stage load/store sequencer: alignment/range checks, one req/ack bus transaction per access,
// byte-enable/store-data formatting, load extension, pipeline stall and AdEL/AdES/DBE fault pulses.
module m_mem_seq #(
   parameter logic [31:0] DM_TOP  = 32'h0000_2FFF,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  dm_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        exc,
   output logic [4:0]  exc_code,
   m_mem_seq_if.master bus
);

   localparam logic [2:0] DM_W  = 3'd0;
   localparam logic [2:0] DM_H  = 3'd1;
   localparam logic [2:0] DM_HU = 3'd2;
   localparam logic [2:0] DM_B  = 3'd3;
   localparam logic [2:0] DM_BU = 3'd4;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   localparam logic [4:0] CODE_ADEL = 5'd4;
   localparam logic [4:0] CODE_ADES = 5'd5;
   localparam logic [4:0] CODE_DBE  = 5'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_RESP,
      S_ERR,
      S_DRAIN
   } state_t;

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [2:0]  r_op;
   logic [1:0]  r_lo;
   logic        r_done;
   logic        r_exc;
   logic [4:0]  r_exc_code;
   logic [31:0] r_rdata;
   logic        r_bus_req;
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [3:0]  r_bus_be;
   logic [31:0] r_bus_wdata;

   logic        w_misalign;
   logic        w_range;
   logic        w_fault;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;

   always_comb begin
      w_misalign = 1'b0;
      w_be       = 4'b0000;
      w_wdata    = wdata;
      case (dm_op)
         DM_W: begin
            w_misalign = (addr[1:0] != 2'b00);
            w_be       = 4'b1111;
         end
         DM_H, DM_HU: begin
            w_misalign = addr[0];
            w_be       = addr[1] ? 4'b1100 : 4'b0011;
            w_wdata    = {2{wdata[15:0]}};
         end
         DM_B, DM_BU: begin
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {4{wdata[7:0]}};
         end
         default: ;
      endcase
   end

   assign w_range = (addr > DM_TOP);
   assign w_fault = w_misalign | w_range;

   // Undefined widths read back as all-ones so a bad decode is visible in the register file.
   function automatic logic [31:0] f_extend(input logic [2:0] op, input logic [1:0] lo,
                                            input logic [31:0] word);
      logic [31:0] sh;
      logic [15:0] hw;
      logic [7:0]  by;
      sh = word >> {lo, 3'b000};
      hw = sh[15:0];
      by = sh[7:0];
      case (op)
         DM_W:    f_extend = word;
         DM_H:    f_extend = {{16{hw[15]}}, hw};
         DM_HU:   f_extend = {16'h0000, hw};
         DM_B:    f_extend = {{24{by[7]}}, by};
         DM_BU:   f_extend = {24'h00_0000, by};
         default: f_extend = 32'hFFFF_FFFF;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_op        <= 3'd0;
         r_lo        <= 2'd0;
         r_done      <= 1'b0;
         r_exc       <= 1'b0;
         r_exc_code  <= 5'd0;
         r_rdata     <= 32'd0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= 32'd0;
         r_bus_be    <= 4'b0000;
         r_bus_wdata <= 32'd0;
      end else begin
         r_done     <= 1'b0;
         r_exc      <= 1'b0;
         r_exc_code <= 5'd0;
         r_rdata    <= 32'd0;
         case (r_state)
            S_IDLE: begin
               if (req && !flush) begin
                  if (w_fault) begin
                     r_state    <= S_ERR;
                     r_exc      <= 1'b1;
                     r_exc_code <= we ? CODE_ADES : CODE_ADEL;
                  end else begin
                     r_state     <= S_WAIT;
                     r_cnt       <= 8'd0;
                     r_op        <= dm_op;
                     r_lo        <= addr[1:0];
                     r_bus_req   <= 1'b1;
                     r_bus_we    <= we;
                     r_bus_addr  <= {addr[31:2], 2'b00};
                     r_bus_be    <= we ? w_be : 4'b0000;
                     r_bus_wdata <= w_wdata;
                  end
               end
            end
            // A flush landing on the ack or timeout cycle simply retires the access silently.
            S_WAIT: begin
               if (bus.bus_ack) begin
                  r_bus_req <= 1'b0;
                  if (flush) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_RESP;
                     r_done  <= 1'b1;
                     r_rdata <= r_bus_we ? 32'd0 : f_extend(r_op, r_lo, bus.bus_rdata);
                  end
               end else if (r_cnt == TO_LAST) begin
                  r_bus_req <= 1'b0;
                  if (flush) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_state    <= S_ERR;
                     r_exc      <= 1'b1;
                     r_exc_code <= CODE_DBE;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
                  if (flush) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (bus.bus_ack || (r_cnt == TO_LAST)) begin
                  r_bus_req <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            S_ERR:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The first cycle of an access must stall before the FSM has registered anything.
   assign stall = !reset &&
                  (((r_state == S_IDLE) && req && !flush) ||
                   (r_state == S_WAIT) || (r_state == S_DRAIN));

   assign done          = r_done;
   assign rdata         = r_rdata;
   assign exc           = r_exc;
   assign exc_code      = r_exc_code;
   assign bus.bus_req   = r_bus_req;
   assign bus.bus_we    = r_bus_we;
   assign bus.bus_addr  = r_bus_addr;
   assign bus.bus_be    = r_bus_be;
   assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_m_mem_seq.sv
// Directed plus randomized bench for m_mem_seq; expectations come from a size/offset based
// reference model of the load/store rules, with one line printed per access.
module tb_m_mem_seq;

   localparam logic [31:0] DM_TOP  = 32'h0000_2FFF;
   localparam int          TIMEOUT = 16;

   localparam logic [2:0] OP_W  = 3'd0;
   localparam logic [2:0] OP_H  = 3'd1;
   localparam logic [2:0] OP_HU = 3'd2;
   localparam logic [2:0] OP_B  = 3'd3;
   localparam logic [2:0] OP_BU = 3'd4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  dm_op = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        flush = 1'b0;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic        exc;
   logic [4:0]  exc_code;

   int n_vec = 0;
   int n_err = 0;

   m_mem_seq_if bus ();

   m_mem_seq #(.DM_TOP(DM_TOP), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .we       (we),
      .dm_op    (dm_op),
      .addr     (addr),
      .wdata    (wdata),
      .flush    (flush),
      .stall    (stall),
      .done     (done),
      .rdata    (rdata),
      .exc      (exc),
      .exc_code (exc_code),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int op_size(input logic [2:0] op);
      case (op)
         OP_W:        return 4;
         OP_H, OP_HU: return 2;
         OP_B, OP_BU: return 1;
         default:     return 0;
      endcase
   endfunction

   // Reference model: access size, offset within the word and signedness drive everything.
   task automatic model(input logic w, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        output bit fault, output logic [3:0] ebe,
                        output logic [31:0] ewd, output logic [31:0] erd);
      int     sz;
      int     off;
      longint mask;
      longint val;
      sz    = op_size(op);
      off   = int'(a % 4);
      fault = (sz != 0 && (a % sz) != 0) || (a > DM_TOP);
      ebe   = 4'b0000;
      ewd   = wd;
      if (w && sz != 0) begin
         ebe = 4'(((1 << sz) - 1) << off);
         for (int i = 0; i < 4; i++) begin
            ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
         end
      end
      if (w) begin
         erd = 32'd0;
      end else if (sz == 0) begin
         erd = 32'hFFFF_FFFF;
      end else begin
         mask = (longint'(1) << (8 * sz)) - 1;
         val  = (longint'(rd) >> (8 * off)) & mask;
         if ((op == OP_H || op == OP_B) && val[8*sz-1]) begin
            val = val | ~mask;
         end
         erd = val[31:0];
      end
   endtask

   // One complete access. ack_at: WAIT cycle index of bus_ack (>= TIMEOUT means never);
   // flush_at: WAIT cycle index of a one-cycle flush, or -1.
   task automatic access(input string name, input logic w, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                         input logic [31:0] rd, input int flush_at,
                         output logic [31:0] o_rd, output logic [3:0] o_be,
                         output logic [31:0] o_wd, output logic o_we);
      bit          fault;
      bit          flushed;
      bit          acked;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      logic [31:0] erd;
      int          k;
      model(w, op, a, wd, rd, fault, ebe, ewd, erd);
      o_rd = 32'd0; o_be = 4'd0; o_wd = 32'd0; o_we = 1'b0;
      flushed = 1'b0;
      acked   = 1'b0;

      step();
      req = 1'b1; we = w; dm_op = op; addr = a; wdata = wd; flush = 1'b0;
      bus.bus_ack = 1'b0;
      #1;
      chk({name, ".idle_stall"}, 32'(stall), 32'd1);
      chk({name, ".idle_bus_req"}, 32'(bus.bus_req), 32'd0);

      if (fault) begin
         step();
         #1;
         chk({name, ".fault_exc"}, 32'(exc), 32'd1);
         chk({name, ".fault_code"}, 32'(exc_code), w ? 32'd5 : 32'd4);
         chk({name, ".fault_stall"}, 32'(stall), 32'd0);
         chk({name, ".fault_bus_req"}, 32'(bus.bus_req), 32'd0);
         chk({name, ".fault_done"}, 32'(done), 32'd0);
         req = 1'b0;
         $display("access %s we=%0b op=%0d addr=%h -> fault code %0d", name, w, op, a, exc_code);
         return;
      end

      k = 0;
      while (1) begin
         step();
         if (flushed) req = 1'b0;
         bus.bus_ack   = (k == ack_at);
         bus.bus_rdata = (k == ack_at) ? rd : $urandom;
         flush         = (k == flush_at);
         #1;
         if (k == 0) begin
            o_be = bus.bus_be;
            o_wd = bus.bus_wdata;
            o_we = bus.bus_we;
         end
         chk({name, ".wait_stall"}, 32'(stall), 32'd1);
         chk({name, ".wait_bus_req"}, 32'(bus.bus_req), 32'd1);
         chk({name, ".wait_addr"}, bus.bus_addr, {a[31:2], 2'b00});
         chk({name, ".wait_be"}, 32'(bus.bus_be), 32'(ebe));
         chk({name, ".wait_we"}, 32'(bus.bus_we), 32'(w));
         if (w && op_size(op) != 0) chk({name, ".wait_wdata"}, bus.bus_wdata, ewd);
         chk({name, ".wait_done"}, 32'(done), 32'd0);
         chk({name, ".wait_exc"}, 32'(exc), 32'd0);
         chk({name, ".wait_code"}, 32'(exc_code), 32'd0);
         if (k == flush_at) flushed = 1'b1;
         if (k == ack_at) begin
            acked = 1'b1;
            break;
         end
         if (k == TIMEOUT - 1) break;
         k++;
      end

      step();
      bus.bus_ack = 1'b0;
      flush = 1'b0;
      #1;
      o_rd = rdata;
      chk({name, ".end_stall"}, 32'(stall), 32'd0);
      chk({name, ".end_bus_req"}, 32'(bus.bus_req), 32'd0);
      if (flushed) begin
         chk({name, ".drain_done"}, 32'(done), 32'd0);
         chk({name, ".drain_exc"}, 32'(exc), 32'd0);
      end else if (acked) begin
         chk({name, ".resp_done"}, 32'(done), 32'd1);
         chk({name, ".resp_rdata"}, rdata, erd);
         chk({name, ".resp_exc"}, 32'(exc), 32'd0);
      end else begin
         chk({name, ".timeout_exc"}, 32'(exc), 32'd1);
         chk({name, ".timeout_code"}, 32'(exc_code), 32'd7);
         chk({name, ".timeout_done"}, 32'(done), 32'd0);
      end
      req = 1'b0;
      $display("access %s we=%0b op=%0d addr=%h ack_at=%0d flush_at=%0d -> done=%0b exc=%0b rdata=%h",
               name, w, op, a, ack_at, flush_at, done, exc, rdata);
   endtask

   initial begin
      logic [31:0] o_rd;
      logic [3:0]  o_be;
      logic [31:0] o_wd;
      logic        o_we;
      logic [2:0]  op;
      logic [31:0] a;
      int          r;
      int          ack_at;
      int          flush_at;

      bus.bus_ack   = 1'b0;
      bus.bus_rdata = 32'd0;
      repeat (3) step();
      #1;
      chk("reset.stall", 32'(stall), 32'd0);
      chk("reset.done", 32'(done), 32'd0);
      chk("reset.exc", 32'(exc), 32'd0);
      chk("reset.rdata", rdata, 32'd0);
      chk("reset.bus_req", 32'(bus.bus_req), 32'd0);
      chk("reset.bus_be", 32'(bus.bus_be), 32'd0);
      reset = 1'b0;

      access("lw_10", 1'b0, OP_W, 32'h10, 32'h0, 0, 32'h8765_4321, -1, o_rd, o_be, o_wd, o_we);
      chk("lw_10.rdata_const", o_rd, 32'h8765_4321);
      chk("lw_10.be_const", 32'(o_be), 32'd0);
      access("lb_13", 1'b0, OP_B, 32'h13, 32'h0, 0, 32'h80FF_0000, -1, o_rd, o_be, o_wd, o_we);
      chk("lb_13.rdata_const", o_rd, 32'hFFFF_FF80);
      access("lbu_13", 1'b0, OP_BU, 32'h13, 32'h0, 1, 32'h80FF_0000, -1, o_rd, o_be, o_wd, o_we);
      chk("lbu_13.rdata_const", o_rd, 32'h0000_0080);
      access("lhu_12", 1'b0, OP_HU, 32'h12, 32'h0, 2, 32'h80FF_0000, -1, o_rd, o_be, o_wd, o_we);
      chk("lhu_12.rdata_const", o_rd, 32'h0000_80FF);
      access("sh_22", 1'b1, OP_H, 32'h22, 32'h1234_ABCD, 0, 32'h0, -1, o_rd, o_be, o_wd, o_we);
      chk("sh_22.be_const", 32'(o_be), 32'h0000_000C);
      chk("sh_22.wdata_const", o_wd, 32'hABCD_ABCD);
      chk("sh_22.we_const", 32'(o_we), 32'd1);
      access("lw_11", 1'b0, OP_W, 32'h11, 32'h0, 0, 32'h0, -1, o_rd, o_be, o_wd, o_we);
      access("sw_3000", 1'b1, OP_W, 32'h3000, 32'h5, 0, 32'h0, -1, o_rd, o_be, o_wd, o_we);
      access("lb_2fff", 1'b0, OP_B, 32'h2FFF, 32'h0, 0, 32'h7F00_0000, -1, o_rd, o_be, o_wd, o_we);
      access("sb_2fff", 1'b1, OP_B, 32'h2FFF, 32'h0000_00A5, 0, 32'h0, -1, o_rd, o_be, o_wd, o_we);
      access("lw_tmo", 1'b0, OP_W, 32'h40, 32'h0, 99, 32'h0, -1, o_rd, o_be, o_wd, o_we);
      access("lw_flush", 1'b0, OP_W, 32'h44, 32'h0, 4, 32'h1234_5678, 1, o_rd, o_be, o_wd, o_we);
      access("lw_undef", 1'b0, 3'd6, 32'h48, 32'h0, 0, 32'h1234_5678, -1, o_rd, o_be, o_wd, o_we);

      // Reset arriving while a transaction is outstanding.
      step();
      req = 1'b1; we = 1'b0; dm_op = OP_W; addr = 32'h50; flush = 1'b0;
      step();
      bus.bus_ack = 1'b0;
      step();
      reset = 1'b1;
      step();
      req = 1'b0;
      #1;
      chk("rst_wait.bus_req", 32'(bus.bus_req), 32'd0);
      chk("rst_wait.stall", 32'(stall), 32'd0);
      chk("rst_wait.done", 32'(done), 32'd0);
      chk("rst_wait.exc", 32'(exc), 32'd0);
      chk("rst_wait.bus_addr", bus.bus_addr, 32'd0);
      $display("access rst_wait -> bus_req=%0b stall=%0b", bus.bus_req, stall);
      reset = 1'b0;

      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 5));
         a  = (i % 6 == 0) ? 32'h2FF0 + 32'($urandom_range(0, 31)) : 32'($urandom_range(0, 32'h2FFF));
         r  = int'($urandom_range(0, 9));
         ack_at   = (r == 9) ? 99 : r % 4;
         flush_at = ($urandom_range(0, 6) == 0) ? 0 : -1;
         if (flush_at >= ack_at) flush_at = -1;
         access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), op, a, $urandom,
                ack_at, $urandom, flush_at, o_rd, o_be, o_wd, o_we);
      end

      repeat (2) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
